// File: rtl/pipe_skid_pkg.sv
// Shared definitions for the elastic pipeline stage register.
// State encoding, default width and an occupancy helper.
package pipe_skid_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } state_e;

    // Occupancy implied by a state; unused code 2'b11 reads as empty.
    function automatic logic [1:0] occ_of(state_e s);
        logic [1:0] n;
        n = 2'd0;
        case (s)
            ST_ONE:  n = 2'd1;
            ST_FULL: n = 2'd2;
            default: n = 2'd0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pipe_skid.sv
// Elastic stage register with a two-entry skid buffer.
// All handshake outputs are registered; ready never sees out_ready.
import pipe_skid_pkg::*;

module pipe_skid #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic [1:0]       count_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [1:0]       count_q;

    logic in_fire;
    logic out_fire;

    assign in_fire  = in_valid_i & in_ready_q;
    assign out_fire = out_valid_q & out_ready_i;

    assign in_ready_o  = in_ready_q;
    assign out_valid_o = out_valid_q;
    assign out_data_o  = main_q;
    assign count_o     = count_q;

    // Next state and data movement; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data_i;
                    end
                end
                ST_ONE: begin
                    case ({in_fire, out_fire})
                        2'b10: begin
                            state_d = ST_FULL;
                            skid_d  = in_data_i;
                        end
                        2'b01: begin
                            state_d = ST_EMPTY;
                        end
                        2'b11: begin
                            main_d = in_data_i;
                        end
                        default: begin
                        end
                    endcase
                end
                ST_FULL: begin
                    // in_ready is low here, so only a drain can happen.
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State, data and registered handshake outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= ST_EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            count_q     <= 2'd0;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= (state_d != ST_FULL);
            out_valid_q <= (state_d == ST_ONE) ||
                           (state_d == ST_FULL);
            count_q     <= occ_of(state_d);
        end
    end

endmodule
